// File: rtl/block_game_ctrl.sv
// Block-killer game sequencer: game state, score and the 4x8 board that
// feeds the VGA display controller. Blocks spawn on top and scroll down.
module block_game_ctrl #(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        key_start,
  input  logic [3:0]  key_col,
  output logic [1:0]  game_state,
  output logic [7:0]  score,
  output logic [23:0] column_0,
  output logic [23:0] column_1,
  output logic [23:0] column_2,
  output logic [23:0] column_3
);

  localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         score_q, score_d;
  logic [3:0][23:0]   cols_q, cols_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [7:0]         lfsr_q, lfsr_d;

  logic [3:0][23:0]   post_hit;
  logic [2:0]         hit_cnt;
  logic               miss;
  logic               scroll;
  logic               bottom_busy;
  logic [8:0]         score_sum;
  logic [2:0]         spawn_colour;

  // Clear the lowest (highest row index) occupied cell of one column.
  function automatic logic [23:0] clear_lowest(input logic [23:0] col);
    logic [23:0] res;
    logic        done;
    res  = col;
    done = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (!done && (col[23-3*k -: 3] != 3'b000)) begin
        res[23-3*k -: 3] = 3'b000;
        done             = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    cols_d       = cols_q;
    tick_d       = tick_q;
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    post_hit     = cols_q;
    hit_cnt      = 3'd0;
    miss         = 1'b0;
    scroll       = 1'b0;
    bottom_busy  = 1'b0;
    score_sum    = 9'd0;
    spawn_colour = (lfsr_q[4:2] == 3'b000) ? 3'b111 : lfsr_q[4:2];

    unique case (state_q)
      ST_START: begin
        if (key_start) begin
          state_d = ST_PLAY;
          score_d = 8'd0;
          cols_d  = '0;
          tick_d  = '0;
        end
      end
      ST_PLAY: begin
        for (int i = 0; i < 4; i++) begin
          if (key_col[i]) begin
            if (cols_q[i] != 24'd0) begin
              post_hit[i] = clear_lowest(cols_q[i]);
              hit_cnt     = hit_cnt + 3'd1;
            end else begin
              miss = 1'b1;
            end
          end
        end
        score_sum = 9'(score_q) + 9'(hit_cnt);
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        scroll    = (tick_q == TICK_LAST);
        tick_d    = scroll ? '0 : tick_q + TICK_W'(1);
        for (int i = 0; i < 4; i++) begin
          bottom_busy = bottom_busy | (post_hit[i][2:0] != 3'b000);
        end
        cols_d = post_hit;
        // Hits land first; a block left on the bottom row at a step ends the game unshifted.
        if (miss) begin
          state_d = ST_OVER;
        end else if (scroll) begin
          if (bottom_busy) begin
            state_d = ST_OVER;
          end else begin
            for (int i = 0; i < 4; i++) begin
              cols_d[i] = {(lfsr_q[1:0] == 2'(i)) ? spawn_colour : 3'b000,
                           post_hit[i][23:3]};
            end
          end
        end
      end
      ST_OVER: begin
        if (key_start) begin
          state_d = ST_START;
          score_d = 8'd0;
          cols_d  = '0;
        end
      end
      default: begin
        state_d = ST_START;
        score_d = 8'd0;
        cols_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_START;
      score_q <= 8'd0;
      cols_q  <= '0;
      tick_q  <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      cols_q  <= cols_d;
      tick_q  <= tick_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign game_state = state_q;
  assign score      = score_q;
  assign column_0   = cols_q[0];
  assign column_1   = cols_q[1];
  assign column_2   = cols_q[2];
  assign column_3   = cols_q[3];

endmodule

// File: tb/tb_block_game_ctrl.sv
// Directed bench for block_game_ctrl: a cell-array game model predicts every
// cycle's outputs into a queue, which is popped and compared after each edge.
module tb_block_game_ctrl;

  localparam int unsigned TICK_DIV = 8;
  localparam logic [7:0]  SEED     = 8'hA5;

  logic        CLK_50M   = 1'b0;
  logic        RST_N     = 1'b0;
  logic        key_start = 1'b0;
  logic [3:0]  key_col   = 4'd0;
  logic [1:0]  game_state;
  logic [7:0]  score;
  logic [23:0] column_0, column_1, column_2, column_3;
  logic [95:0] dcols;

  assign dcols = {column_3, column_2, column_1, column_0};

  block_game_ctrl #(.TICK_DIV(TICK_DIV), .LFSR_SEED(SEED)) dut (
    .CLK_50M   (CLK_50M),
    .RST_N     (RST_N),
    .key_start (key_start),
    .key_col   (key_col),
    .game_state(game_state),
    .score     (score),
    .column_0  (column_0),
    .column_1  (column_1),
    .column_2  (column_2),
    .column_3  (column_3)
  );

  always #10 CLK_50M = ~CLK_50M;

  typedef struct packed {
    logic [1:0]  st;
    logic [7:0]  sc;
    logic [95:0] cols;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Game model: board[c][r], r=0 is the top row.
  logic [1:0] m_state;
  logic [7:0] m_score;
  logic [2:0] m_board [4][8];
  int         m_tick;
  logic [7:0] m_lfsr;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  function automatic logic [23:0] m_col(input int c);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[23-3*k -: 3] = m_board[c][k];
    return r;
  endfunction

  function automatic logic [95:0] m_cols();
    return {m_col(3), m_col(2), m_col(1), m_col(0)};
  endfunction

  function automatic logic [3:0] bottom_mask();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (m_board[c][7] != 3'b000);
    return r;
  endfunction

  function automatic bit all_occ();
    bit r;
    r = 1'b1;
    for (int c = 0; c < 4; c++) if (m_col(c) == 24'd0) r = 1'b0;
    return r;
  endfunction

  task automatic m_clear_board();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++) m_board[c][r] = 3'b000;
  endtask

  task automatic m_reset();
    m_state = 2'b00;
    m_score = 8'd0;
    m_tick  = 0;
    m_lfsr  = SEED;
    m_clear_board();
  endtask

  task automatic m_step(input logic st, input logic [3:0] kc);
    int       hits;
    bit       miss;
    bit       scroll;
    bit       busy;
    logic [2:0] colour;
    case (m_state)
      2'b00: if (st) begin
        m_state = 2'b01;
        m_score = 8'd0;
        m_tick  = 0;
        m_clear_board();
      end
      2'b01: begin
        hits = 0;
        miss = 1'b0;
        for (int c = 0; c < 4; c++) begin
          if (kc[c]) begin
            int r;
            r = 7;
            while (r >= 0 && m_board[c][r] == 3'b000) r--;
            if (r < 0) miss = 1'b1;
            else begin
              m_board[c][r] = 3'b000;
              hits++;
            end
          end
        end
        m_score = (int'(m_score) + hits > 255) ? 8'd255 : 8'(int'(m_score) + hits);
        scroll  = (m_tick == int'(TICK_DIV) - 1);
        m_tick  = scroll ? 0 : m_tick + 1;
        if (miss) m_state = 2'b10;
        else if (scroll) begin
          busy = 1'b0;
          for (int c = 0; c < 4; c++) if (m_board[c][7] != 3'b000) busy = 1'b1;
          if (busy) m_state = 2'b10;
          else begin
            colour = (m_lfsr[4:2] == 3'b000) ? 3'b111 : m_lfsr[4:2];
            for (int c = 0; c < 4; c++) begin
              for (int r = 7; r > 0; r--) m_board[c][r] = m_board[c][r-1];
              m_board[c][0] = (c == int'(m_lfsr[1:0])) ? colour : 3'b000;
            end
          end
        end
      end
      2'b10: if (st) begin
        m_state = 2'b00;
        m_score = 8'd0;
        m_clear_board();
      end
      default: m_state = 2'b00;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // One clock: drive, predict into the queue, then pop and compare after the edge.
  task automatic cyc(input logic st, input logic [3:0] kc);
    exp_t e;
    key_start = st;
    key_col   = kc;
    m_step(st, kc);
    e.st   = m_state;
    e.sc   = m_score;
    e.cols = m_cols();
    exp_q.push_back(e);
    @(posedge CLK_50M);
    #1;
    key_start = 1'b0;
    key_col   = 4'd0;
    e = exp_q.pop_front();
    chk("state", 96'(game_state), 96'(e.st));
    chk("score", 96'(score), 96'(e.sc));
    chk("board", dcols, e.cols);
  endtask

  initial begin
    logic [3:0]  bm;
    logic [95:0] snap;
    int          ec;
    int          cnt;

    m_reset();
    RST_N = 1'b0;
    #45;
    chk("rst_state", 96'(game_state), 96'd0);
    chk("rst_score", 96'(score), 96'd0);
    chk("rst_board", dcols, 96'd0);
    RST_N = 1'b1;

    // Idle after reset
    repeat (100) cyc(1'b0, 4'd0);

    // Start and first spawn
    cyc(1'b1, 4'd0);
    chk("start_state", 96'(game_state), 96'd1);
    repeat (8) cyc(1'b0, 4'd0);
    cnt = int'(column_0[23:21] != 3'b000) + int'(column_1[23:21] != 3'b000) +
          int'(column_2[23:21] != 3'b000) + int'(column_3[23:21] != 3'b000);
    chk("one_spawn", 96'(cnt), 96'd1);

    // Scroll a block to row 7 and clear it
    for (int i = 0; i < 100 && bottom_mask() == 4'd0; i++) cyc(1'b0, 4'd0);
    bm = bottom_mask();
    chk("reach_row7", 96'(bm != 4'd0), 96'd1);
    cyc(1'b0, bm);
    chk("hit_score", 96'(score), 96'd1);
    chk("hit_bottom", 96'({column_3[2:0], column_2[2:0], column_1[2:0], column_0[2:0]}), 96'd0);

    // Miss on an empty column, frozen OVER, then restart
    ec = -1;
    for (int i = 0; i < 200 && ec < 0; i++) begin
      for (int c = 0; c < 4; c++) if (m_col(c) == 24'd0) ec = c;
      if (ec < 0) cyc(1'b0, bottom_mask());
    end
    chk("empty_found", 96'(ec >= 0), 96'd1);
    if (ec >= 0) cyc(1'b0, 4'(1 << ec));
    chk("miss_state", 96'(game_state), 96'd2);
    snap = dcols;
    repeat (50) cyc(1'b0, 4'($urandom_range(0, 15)));
    chk("over_frozen", dcols, snap);
    cyc(1'b1, 4'd0);
    chk("over_to_start", 96'(game_state), 96'd0);
    cyc(1'b1, 4'd0);
    chk("restart_state", 96'(game_state), 96'd1);
    chk("restart_score", 96'(score), 96'd0);
    chk("restart_board", dcols, 96'd0);

    // Unhit block on the bottom row ends the game at the next step, unshifted
    snap = m_cols();
    for (int i = 0; i < 300 && m_state == 2'b01; i++) begin
      snap = m_cols();
      cyc(1'b0, 4'd0);
    end
    chk("bottom_over", 96'(game_state), 96'd2);
    chk("bottom_noshift", dcols, snap);

    // Same-clock hit rescues the step
    cyc(1'b1, 4'd0);
    cyc(1'b1, 4'd0);
    for (int i = 0; i < 300 && !(m_tick == int'(TICK_DIV) - 1 && bottom_mask() != 4'd0); i++)
      cyc(1'b0, 4'd0);
    bm = bottom_mask();
    chk("rescue_setup", 96'(bm != 4'd0), 96'd1);
    cyc(1'b0, bm);
    chk("rescue_state", 96'(game_state), 96'd1);

    // Build the score up, then a four-column hit that saturates
    for (int i = 0; i < 6000 && m_state == 2'b01 && !(m_score >= 8'd252 && all_occ()); i++)
      cyc(1'b0, bottom_mask());
    chk("sat_setup", 96'(score >= 8'd252 && game_state == 2'b01), 96'd1);
    cyc(1'b0, 4'hF);
    chk("sat_score", 96'(score), 96'd255);
    chk("sat_state", 96'(game_state), 96'd1);
    repeat (40) cyc(1'b0, bottom_mask());
    chk("sat_hold", 96'(score), 96'd255);

    // Asynchronous reset mid-game
    chk("pre_reset_play", 96'(game_state), 96'd1);
    #4;
    RST_N = 1'b0;
    #2;
    chk("async_state", 96'(game_state), 96'd0);
    chk("async_score", 96'(score), 96'd0);
    chk("async_board", dcols, 96'd0);
    #1;
    RST_N = 1'b1;
    m_reset();
    repeat (5) cyc(1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
